// File: rtl/zle_pkg.sv
// Shared definitions for the zero-length encoder: FSM encoding, token field
// constants and the control word passed from the FSM to the datapath.
package zle_pkg;

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_ZEROS = 2'd1;
    localparam logic [1:0] ST_PEND  = 2'd2;

    localparam logic LIT_FLAG = 1'b0;
    localparam logic RUN_FLAG = 1'b1;
    // EOS token: payload all-zero, o_e set
    localparam logic EOS_FLAG = 1'b1;

    typedef enum logic [2:0] {
        SRC_LIT,
        SRC_RUN,
        SRC_FULL,
        SRC_EOS,
        SRC_PEND
    } tok_src_e;

    typedef struct packed {
        logic     ld_slot;
        tok_src_e src;
        logic     cnt_clr;
        logic     cnt_inc;
        logic     pend_ld;
    } zle_ctl_t;

    // Run flag sits just above the W-bit literal field
    function automatic int run_bit(input int w);
        return w;
    endfunction

endpackage

// File: rtl/zle_param_dp.sv
// Datapath: output slot, run counter, pending token register and the mux
// that builds the next output token.
module zle_param_dp
    import zle_pkg::*;
#(
    parameter int W = 8,
    parameter int C = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  zle_ctl_t     ctl,
    input  logic [W-1:0] i_d,
    input  logic         i_e,
    input  logic         o_b,
    output logic [W:0]   o_d,
    output logic         o_e,
    output logic         o_v,
    output logic         slot_free,
    output logic         is_zero,
    output logic         cnt_last
);

    localparam logic [C-1:0] CNT_ONES = '1;
    localparam logic [C-1:0] CNT_LAST = CNT_ONES - C'(1);

    logic [C-1:0] cnt;
    logic [W-1:0] pend_d;
    logic         pend_e;
    logic [W:0]   nxt_d;
    logic         nxt_e;

    assign slot_free = !o_v || !o_b;
    assign is_zero   = !i_e && (i_d == '0);
    assign cnt_last  = (cnt == CNT_LAST);

    always_comb begin
        nxt_d = '0;
        nxt_e = 1'b0;
        case (ctl.src)
            SRC_LIT:  nxt_d = {LIT_FLAG, i_d};
            SRC_RUN: begin
                nxt_d[run_bit(W)] = RUN_FLAG;
                nxt_d[C-1:0]      = cnt;
            end
            SRC_FULL: begin
                nxt_d[run_bit(W)] = RUN_FLAG;
                nxt_d[C-1:0]      = CNT_ONES;
            end
            SRC_EOS:  nxt_e = EOS_FLAG;
            SRC_PEND: begin
                // pending holds either a nonzero literal or an EOS
                if (pend_e) nxt_e = EOS_FLAG;
                else        nxt_d = {LIT_FLAG, pend_d};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_v <= 1'b0;
            o_e <= 1'b0;
            o_d <= '0;
        end else if (ctl.ld_slot) begin
            o_v <= 1'b1;
            o_e <= nxt_e;
            o_d <= nxt_d;
        end else if (o_v && !o_b) begin
            o_v <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           cnt <= '0;
        else if (ctl.cnt_clr) cnt <= '0;
        else if (ctl.cnt_inc) cnt <= cnt + C'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_d <= '0;
            pend_e <= 1'b0;
        end else if (ctl.pend_ld) begin
            pend_d <= i_d;
            pend_e <= i_e;
        end
    end

endmodule

// File: rtl/zle_param.sv
// Zero-length encoder top: collapses runs of zero literals into run tokens.
// Control FSM lives here; storage and token formatting live in zle_param_dp.
module zle_param
    import zle_pkg::*;
#(
    parameter int W = 8,
    parameter int C = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    input  logic         i_e,
    input  logic         i_v,
    output logic         i_b,
    output logic [W:0]   o_d,
    output logic         o_e,
    output logic         o_v,
    input  logic         o_b
);

    logic [1:0] state, state_nxt;
    zle_ctl_t   ctl;
    logic       slot_free, is_zero, cnt_last, accept;

    // Busy follows o_b combinationally so a stalled slot back-pressures input
    assign i_b    = !reset || (state == ST_PEND) || !slot_free;
    assign accept = i_v && !i_b;

    always_comb begin
        ctl       = '0;
        ctl.src   = SRC_LIT;
        state_nxt = state;
        case (state)
            ST_START: if (accept) begin
                if (i_e) begin
                    ctl.ld_slot = 1'b1;
                    ctl.src     = SRC_EOS;
                end else if (is_zero) begin
                    ctl.cnt_clr = 1'b1;
                    state_nxt   = ST_ZEROS;
                end else begin
                    ctl.ld_slot = 1'b1;
                end
            end
            ST_ZEROS: if (accept) begin
                if (is_zero && cnt_last) begin
                    ctl.ld_slot = 1'b1;
                    ctl.src     = SRC_FULL;
                    state_nxt   = ST_START;
                end else if (is_zero) begin
                    ctl.cnt_inc = 1'b1;
                end else begin
                    ctl.ld_slot = 1'b1;
                    ctl.src     = SRC_RUN;
                    ctl.pend_ld = 1'b1;
                    state_nxt   = ST_PEND;
                end
            end
            ST_PEND: if (slot_free) begin
                ctl.ld_slot = 1'b1;
                ctl.src     = SRC_PEND;
                state_nxt   = ST_START;
            end
            default: state_nxt = ST_START;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_START;
        else        state <= state_nxt;
    end

    zle_param_dp #(.W(W), .C(C)) u_dp (
        .clock     (clock),
        .reset     (reset),
        .ctl       (ctl),
        .i_d       (i_d),
        .i_e       (i_e),
        .o_b       (o_b),
        .o_d       (o_d),
        .o_e       (o_e),
        .o_v       (o_v),
        .slot_free (slot_free),
        .is_zero   (is_zero),
        .cnt_last  (cnt_last)
    );

endmodule

// File: doc/zle_param.md
ZLE_PARAM -- requirements
Module: zle_param

Interface
REQ-001 SHALL have parameter W, default 8, meaning input literal width in bits.
REQ-002 SHALL have parameter C, default 4, meaning run-count field width; maximum run length is 2^C; legal only when 1 <= C <= W.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port i_d, input, W, meaning input token data.
REQ-006 SHALL have port i_e, input, 1, meaning input token is end-of-stream; i_d ignored when set.
REQ-007 SHALL have port i_v, input, 1, meaning input token valid.
REQ-008 SHALL have port i_b, output, 1, meaning block busy; input token transfers when i_v=1 and i_b=0.
REQ-009 SHALL have port o_d, output, W+1, meaning output token: MSB=0 literal (low W bits); MSB=1 zero run (low C bits = length-1, other bits 0).
REQ-010 SHALL have port o_e, output, 1, meaning output token is end-of-stream; o_d=0 when set.
REQ-011 SHALL have port o_v, output, 1, meaning output token valid.
REQ-012 SHALL have port o_b, input, 1, meaning downstream busy; output token transfers when o_v=1 and o_b=0.

Function
REQ-013 SHALL hold one registered output slot; slot_free = !o_v || !o_b; latency input transfer to o_v = 1 cycle.
REQ-014 SHALL drive i_b = (state==PEND) || !slot_free, combinational; i_b path from o_b is intentional.
REQ-015 SHALL keep o_d/o_e/o_v stable while o_v=1 and o_b=1; o_v drops after transfer unless slot is reloaded in the same cycle.
REQ-016 SHALL implement states START, ZEROS, PEND with a C-bit counter cnt and a pending register (W data bits + eos bit).
REQ-017 START, nonzero literal accepted: load {0,i_d} into slot, stay START.
REQ-018 START, zero accepted: cnt=0, go ZEROS, slot not loaded.
REQ-019 START, EOS accepted: load EOS token (o_e=1), stay START; no run token emitted.
REQ-020 ZEROS, zero accepted with cnt < 2^C-2: cnt=cnt+1, stay ZEROS.
REQ-021 ZEROS, zero accepted with cnt == 2^C-2: load run token with count 2^C-1, go START.
REQ-022 ZEROS with C=1: the first accepted zero after START follows REQ-021 (cnt==0 == 2^C-2... count 2^C-1), i.e. two zeros form a full run.
REQ-023 ZEROS, nonzero or EOS accepted: load run token with count cnt, store the token in pending register, go PEND.
REQ-024 PEND: accept no input; when slot_free, load pending token into slot, go START.
REQ-025 SHALL never drop, duplicate or reorder tokens under any o_b pattern.
REQ-026 SHALL treat a token following EOS as the start of a new stream (state START, no carried count).

Reset
REQ-027 While reset=0: o_v=0, o_e=0, o_d=0, i_b=1, state=START, cnt=0, pending cleared; asynchronous assertion, deassertion sampled at next clock.
REQ-028 Reset mid-run SHALL discard the partial run without emitting it.

Structure
REQ-029 Shared package zle_pkg SHALL hold state encoding (START, ZEROS, PEND) and token field constants (run-flag bit position, EOS encoding).
REQ-030 SHALL split into control FSM in zle_param and one sub-module zle_param_dp (slot register, counter, pending register, zero/max-count flags, o_d mux).

Verification (W=8, C=4, o_b=0 unless stated)
REQ-031 Literals 0x05,0x07 back-to-back -> o_d 0x005 then 0x007 on consecutive cycles, 1-cycle latency, i_b=0 throughout.
REQ-032 Input 0,0,0,0x09 -> o_d 0x102 then 0x009; i_b=1 for exactly one cycle (PEND).
REQ-033 20 zeros then EOS -> 0x10F, 0x103, then o_e=1 o_d=0x000; no further tokens.
REQ-034 o_v=1 with o_b held 1 for 5 cycles -> o_d stable, i_b=1, input stream resumes with no loss after o_b=0.
REQ-035 Three zeros, reset pulsed low mid-stream, then 0,0x01,EOS -> o_v=0 during reset; afterwards only 0x100, 0x001, EOS token.
REQ-036 EOS as first token after reset -> single EOS token, no run token; random i_v/o_b soak checked against a reference-model scoreboard.
